frame_capture256: RTL and testbench
===================================

# frame_capture256

Downstream companion to the 256-bit serial-in/parallel-out shift register in the decoder256 datapath. Counts bits as they are shifted into the SIPO, detects frame completion after SIZE shifts, and snapshots the SIPO's parallel output into a holding register. The captured word is presented to the decoder core through a valid/ready handshake, with overrun detection and a wrapping frame counter.

## Interface
- SIZE, 256, frame width in bits; equals the SIPO width.
- CNT_W, 8, bit-counter width; CNT_W = log2(SIZE), and SIZE is a power of two.
- clk  in  1  single clock; all state updates on the rising edge.
- clear  in  1  asynchronous, active-high reset.
- shift_en  in  1  same signal that drives the SIPO enable; high means one bit is shifted in at this edge.
- par_in  in  SIZE  SIPO parallel output.
- flush  in  1  synchronous abort of the partial frame.
- word_out  out  SIZE  captured frame; stable while word_valid = 1.
- word_valid  out  1  captured word available.
- word_ready  in  1  consumer accepts word_out at this edge when word_valid = 1.
- overrun  out  1  sticky: a completed frame was dropped.
- bit_count  out  CNT_W  bits shifted into the current frame.
- frame_cnt  out  16  frames successfully captured; wraps from 0xFFFF to 0.

## Operation
- Reset (clear = 1, asynchronous) sets:
  - word_out = 0, word_valid = 0, overrun = 0, bit_count = 0, frame_cnt = 0;
  - FSM = FILL.
- FSM has two states:
  - FILL: normal counting.
  - CAPT: last bit shifted on the previous edge; par_in now holds the full frame.
- bit_count:
  - increments on each edge with shift_en = 1;
  - wraps from SIZE-1 to 0 in every state.
- FILL -> CAPT: on an edge where shift_en = 1 and bit_count = SIZE-1 (the completing shift).
- CAPT -> FILL: unconditionally on the next edge. At that edge the block samples par_in, the pre-edge value and therefore the complete frame.
  - Shifts during CAPT count toward the next frame, so bit_count reads 0 or 1 after the edge.
- Capture action at the CAPT edge:
  - If word_valid = 0, or word_valid = 1 and word_ready = 1 at this edge: load word_out = par_in, set word_valid = 1, and increment frame_cnt.
  - Otherwise (old word still pending): keep word_out and word_valid unchanged, set overrun = 1, and leave frame_cnt unchanged. The new frame is dropped.
- Handshake:
  - word_valid falls on the edge where word_valid & word_ready, unless a capture reloads it at the same edge.
  - word_out never changes while word_valid = 1, except on an accept+capture edge.
  - word_ready while word_valid = 0 is ignored.
- flush (synchronous) has the highest priority after clear:
  - sets bit_count = 0 and FSM = FILL;
  - cancels a pending CAPT, so no capture occurs and overrun is not set;
  - a simultaneous shift_en is not counted.
  - flush does not touch word_out, word_valid, overrun or frame_cnt. A simultaneous accept (word_valid & word_ready) still completes.
- overrun is cleared only by clear.

## Timing
- The last shift is presented in cycle N (shift_en = 1, bit_count = SIZE-1):
  - edge N: SIPO loads the final bit; FSM = CAPT; bit_count = 0.
  - edge N+1: word_out = frame and word_valid = 1, visible in cycle N+2.
  - Capture latency is two edges from the completing shift.
- Minimum frame period is SIZE cycles. Back-to-back frames with a consumer that always has word_ready = 1 never overrun.
- All outputs are registered; no combinational path from input to output.
- Assertion of clear mid-frame or in CAPT immediately discards all state. The SIPO is cleared by the same clear signal.

## Test plan
- Reset: assert clear mid-frame after 100 shifts -> all outputs 0, FSM = FILL. After release, 256 shifts are required for a capture.
- Single frame: shift 256 bits of pattern 0xA5 repeated, word_ready = 0 -> word_valid rises 2 edges after the 256th shift, word_out = pattern, frame_cnt = 1. Raise word_ready for 1 cycle -> word_valid falls.
- Overrun: capture frame A and hold word_ready = 0, then shift frame B -> word_out still equals A, overrun = 1, frame_cnt = 1. Accept A, then shift frame C -> word_out = C, frame_cnt = 2, overrun stays 1.
- Accept+capture same edge: word_ready = 1 exactly at B's CAPT edge while A is valid -> word_out = B, word_valid stays 1, overrun = 0.
- Flush: flush at bit_count = 37 with shift_en = 1 -> bit_count = 0. Flush in CAPT -> no capture, frame_cnt unchanged, then 256 more shifts capture normally.
- Continuous streaming: 4 back-to-back frames with word_ready = 1 and shift_en = 1 every cycle -> 4 captures, each frame's word correct, bit_count = 1 after each capture edge, overrun = 0.

Source files
------------

// File: rtl/frame_capture256.sv
// frame_capture256: counts bits shifted into the companion SIPO, detects frame
// completion, and holds the completed frame for the decoder core behind a
// valid/ready handshake. It also flags dropped frames and counts captured frames.
//
// state | meaning
// ------+---------------------------------------------------------------
// FILL  | counting shifts of the current frame
// CAPT  | last bit landed on the previous edge; par_in_i holds the frame
module frame_capture256 #(
  parameter int SIZE  = 256,
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             clear_i,
  input  logic             shift_en_i,
  input  logic [SIZE-1:0]  par_in_i,
  input  logic             flush_i,
  output logic [SIZE-1:0]  word_out_o,
  output logic             word_valid_o,
  input  logic             word_ready_i,
  output logic             overrun_o,
  output logic [CNT_W-1:0] bit_count_o,
  output logic [15:0]      frame_cnt_o
);

  typedef enum logic {
    FILL = 1'b0,
    CAPT = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SIZE - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] bit_count_q, bit_count_d;
  logic [SIZE-1:0]  word_q, word_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic             accept;

  assign accept = valid_q & word_ready_i;

  // State register and all output registers; clear discards everything at once.
  always_ff @(posedge clk_i or posedge clear_i) begin
    if (clear_i) begin
      state_q     <= FILL;
      bit_count_q <= '0;
      word_q      <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      bit_count_q <= bit_count_d;
      word_q      <= word_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Next-state: bit counting, frame completion, capture/overrun and handshake.
  always_comb begin
    state_d     = state_q;
    bit_count_d = bit_count_q;
    word_d      = word_q;
    valid_d     = valid_q;
    overrun_d   = overrun_q;
    frame_cnt_d = frame_cnt_q;

    // An accepted word retires unless a capture reloads it below.
    if (accept) begin
      valid_d = 1'b0;
    end

    if (flush_i) begin
      // Abort the partial frame; a pending capture is cancelled silently.
      bit_count_d = '0;
      state_d     = FILL;
    end else begin
      // Shifts during CAPT already belong to the next frame.
      if (shift_en_i) begin
        bit_count_d = bit_count_q + CNT_W'(1);
      end
      unique case (state_q)
        FILL: begin
          if (shift_en_i && (bit_count_q == LAST_BIT)) begin
            state_d = CAPT;
          end
        end
        CAPT: begin
          state_d = FILL;
          if (!valid_q || accept) begin
            word_d      = par_in_i;
            valid_d     = 1'b1;
            frame_cnt_d = frame_cnt_q + 16'd1;
          end else begin
            overrun_d = 1'b1;
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  assign word_out_o   = word_q;
  assign word_valid_o = valid_q;
  assign overrun_o    = overrun_q;
  assign bit_count_o  = bit_count_q;
  assign frame_cnt_o  = frame_cnt_q;

endmodule

// File: tb/tb_frame_capture256.sv
// Bench for frame_capture256: drives a behavioural SIPO, keeps a frame-level
// model of the expected outputs and compares every cycle, plus literal checks.
module tb_frame_capture256;

  localparam int SIZE = 256;

  logic            clk = 1'b0;
  logic            clear = 1'b0;
  logic            shift_en = 1'b0;
  logic            flush = 1'b0;
  logic            word_ready = 1'b0;
  logic [SIZE-1:0] sipo = '0;
  logic [SIZE-1:0] word_out;
  logic            word_valid;
  logic            overrun;
  logic [7:0]      bit_count;
  logic [15:0]     frame_cnt;

  frame_capture256 #(.SIZE(SIZE), .CNT_W(8)) dut (
    .clk_i        (clk),
    .clear_i      (clear),
    .shift_en_i   (shift_en),
    .par_in_i     (sipo),
    .flush_i      (flush),
    .word_out_o   (word_out),
    .word_valid_o (word_valid),
    .word_ready_i (word_ready),
    .overrun_o    (overrun),
    .bit_count_o  (bit_count),
    .frame_cnt_o  (frame_cnt)
  );

  always #5 clk = ~clk;

  int n_tot = 0;
  int n_bad = 0;

  // Frame-level model: shifts counted into the current frame, whether the
  // frame completed on the last edge, and the consumer-visible word state.
  int              m_cnt;
  bit              m_done;
  logic [SIZE-1:0] m_word;
  bit              m_valid;
  bit              m_ovr;
  int              m_fcnt;
  bit              m_capt_now;

  logic [SIZE-1:0] a_word, b_word, c_word;
  logic [7:0]      pat;

  task automatic chk(input string nm, input logic [SIZE-1:0] act, input logic [SIZE-1:0] exp);
    n_tot++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("word_out",   word_out,          m_word);
    chk("word_valid", SIZE'(word_valid), SIZE'(m_valid));
    chk("overrun",    SIZE'(overrun),    SIZE'(m_ovr));
    chk("bit_count",  SIZE'(bit_count),  SIZE'(m_cnt));
    chk("frame_cnt",  SIZE'(frame_cnt),  SIZE'(m_fcnt));
  endtask

  task automatic model_reset();
    m_cnt      = 0;
    m_done     = 0;
    m_word     = '0;
    m_valid    = 0;
    m_ovr      = 0;
    m_fcnt     = 0;
    m_capt_now = 0;
  endtask

  // One clock: drive inputs, apply the rules at the edge, compare at negedge.
  task automatic tick(input bit sh, input bit b, input bit fl, input bit rd);
    logic [SIZE-1:0] frame_pre;
    bit acc, was_done;
    shift_en   = sh;
    flush      = fl;
    word_ready = rd;
    @(posedge clk);
    frame_pre  = sipo;
    acc        = m_valid && rd;
    m_capt_now = 0;
    if (fl) begin
      m_cnt  = 0;
      m_done = 0;
      if (acc) m_valid = 0;
    end else begin
      was_done = m_done;
      m_done   = sh && (m_cnt == SIZE - 1);
      if (sh) m_cnt = (m_cnt + 1) % SIZE;
      if (was_done && (!m_valid || acc)) begin
        m_word     = frame_pre;
        m_valid    = 1;
        m_fcnt     = (m_fcnt + 1) % 65536;
        m_capt_now = 1;
      end else begin
        if (was_done) m_ovr = 1;
        if (acc) m_valid = 0;
      end
    end
    if (sh) sipo <= {sipo[SIZE-2:0], b};
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_clear();
    shift_en   = 0;
    flush      = 0;
    word_ready = 0;
    #1;
    clear = 1;
    sipo  = '0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    compare_all();
    clear = 0;
  endtask

  task automatic shifts(input int n, input bit rd);
    for (int i = 0; i < n; i++) tick(1'b1, 1'($urandom_range(0, 1)), 1'b0, rd);
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    do_clear();
    chk("reset_valid", SIZE'(word_valid), '0);
    chk("reset_word", word_out, '0);

    // Clear mid-frame, then a full 256 shifts are needed for a capture.
    shifts(100, 1'b0);
    chk("pre_clear_cnt", SIZE'(bit_count), SIZE'(100));
    do_clear();
    chk("mid_clear_cnt", SIZE'(bit_count), '0);
    shifts(255, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    chk("no_early_capt", SIZE'(word_valid), '0);
    shifts(1, 1'b0);
    chk("capt_lat_n", SIZE'(word_valid), '0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    chk("capt_lat_n1", SIZE'(word_valid), SIZE'(1));

    // Single frame of 0xA5 bytes, consumer not ready.
    do_clear();
    pat = 8'hA5;
    for (int i = 0; i < SIZE; i++) tick(1'b1, pat[7 - (i % 8)], 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    chk("a5_valid", SIZE'(word_valid), SIZE'(1));
    chk("a5_word", word_out, {32{8'hA5}});
    chk("a5_fcnt", SIZE'(frame_cnt), SIZE'(1));
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    chk("a5_accept", SIZE'(word_valid), '0);

    // Overrun: B dropped while A pending, C captured after A accepted.
    do_clear();
    shifts(SIZE, 1'b0);
    a_word = sipo;
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    shifts(SIZE, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    chk("ovr_word_a", word_out, a_word);
    chk("ovr_flag", SIZE'(overrun), SIZE'(1));
    chk("ovr_fcnt", SIZE'(frame_cnt), SIZE'(1));
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    shifts(SIZE, 1'b0);
    c_word = sipo;
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    chk("ovr_word_c", word_out, c_word);
    chk("ovr_fcnt2", SIZE'(frame_cnt), SIZE'(2));
    chk("ovr_sticky", SIZE'(overrun), SIZE'(1));

    // Accept and capture on the same edge.
    do_clear();
    shifts(SIZE, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    shifts(SIZE, 1'b0);
    b_word = sipo;
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    chk("acc_capt_word", word_out, b_word);
    chk("acc_capt_valid", SIZE'(word_valid), SIZE'(1));
    chk("acc_capt_ovr", SIZE'(overrun), '0);

    // Flush mid-frame and in CAPT.
    do_clear();
    shifts(37, 1'b0);
    chk("flush_pre", SIZE'(bit_count), SIZE'(37));
    tick(1'b1, 1'b1, 1'b1, 1'b0);
    chk("flush_cnt", SIZE'(bit_count), '0);
    shifts(SIZE, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    chk("flush_capt_valid", SIZE'(word_valid), '0);
    chk("flush_capt_fcnt", SIZE'(frame_cnt), '0);
    shifts(SIZE, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    chk("flush_after_fcnt", SIZE'(frame_cnt), SIZE'(1));

    // Continuous streaming with an always-ready consumer.
    do_clear();
    for (int i = 0; i < 4 * SIZE + 1; i++) begin
      tick(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
      if (m_capt_now) chk("stream_cnt", SIZE'(bit_count), SIZE'(1));
    end
    chk("stream_fcnt", SIZE'(frame_cnt), SIZE'(4));
    chk("stream_ovr", SIZE'(overrun), '0);

    // Randomized traffic against the model.
    do_clear();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 999) < 2) do_clear();
      else tick($urandom_range(0, 9) < 8, 1'($urandom_range(0, 1)),
                $urandom_range(0, 199) == 0, $urandom_range(0, 9) < 3);
    end

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
